stopwatch_bcd_counter: RTL and testbench
========================================

Name: stopwatch_bcd_counter

Overview:
- Timekeeping core of the stopwatch lab. It consumes the system clock and produces a 4-digit BCD elapsed time in the format M:SS.t (minutes, seconds tens, seconds units, tenths).
- Each digit increments through the same 4-bit add-with-carry structure the adder stage provides.
- Its digits output feeds the 7-segment display multiplexer downstream.
- Control inputs arrive as single-cycle pulses from the upstream debounce and edge-detect stage.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per tenth-second tick (10_000_000 gives 0.1 s at 100 MHz). Legal range is 2 or more.
- CNT_W, 24, prescaler width. It must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_stop  input  1  single-cycle pulse that toggles between run and pause.
- clear  input  1  single-cycle pulse that zeroes the time (not honoured while running).
- lap  input  1  single-cycle pulse that toggles the lap freeze. It is only functional with LAP_EN.
- digits  output  16  {min[15:12], sec_tens[11:8], sec_units[7:4], tenths[3:0]}, all BCD.
- running  output  1  high while the state is RUN.
- rollover  output  1  one-cycle pulse on the wrap from 9:59.9 to 0:00.0.
- frozen  output  1  high while the lap freeze is active. Tied to 0 without LAP_EN.

Behaviour:
- Reset: this is a synchronous, active-high reset, sampled on the rising edge of clk. On reset:
  - state goes to IDLE;
  - prescaler and all digits go to 0;
  - digits = 16'h0000;
  - running = 0, rollover = 0, frozen = 0.
  - Reset dominates every other input. Reset asserted mid-count takes effect at the next edge.
- FSM states: IDLE, RUN, PAUSE. Transitions, evaluated on each clk edge:
  - IDLE with start_stop -> RUN.
  - RUN with start_stop -> PAUSE.
  - PAUSE with start_stop -> RUN.
  - IDLE or PAUSE with clear -> IDLE, with digits and prescaler zeroed.
  - clear is ignored in RUN.
  - clear and start_stop in the same cycle: in IDLE or PAUSE, clear wins (result is IDLE and cleared); in RUN, start_stop wins (result is PAUSE, no clear).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Tick is asserted, combinationally, when the prescaler equals TICK_DIV-1 in RUN; the prescaler then returns to 0.
  - The prescaler holds its value in PAUSE, so a resumed interval completes its remaining cycles. It is zeroed by clear and reset.
- Increment chain, on the tick cycle, with the result registered at that edge:
  - tenths: 0..9. At 9 it wraps to 0 and carries.
  - sec_units: 0..9. On carry-in at 9 it wraps to 0 and carries.
  - sec_tens: 0..5. On carry-in at 5 it wraps to 0 and carries.
  - min: 0..9. On carry-in at 9 it wraps to 0 and raises rollover for exactly one cycle.
  - Each digit computes digit+carry_in with 4-bit arithmetic; wrap detection happens before the add, so no non-BCD value ever appears on digits.
- Latency:
  - The first increment lands TICK_DIV cycles after the edge that enters RUN from a cleared state.
  - digits and rollover are registered outputs and change on the same edge as the internal digit registers.
- rollover: counting continues through a rollover; the stopwatch does not stop.
- running: registered and equal to (state == RUN).

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse in RUN toggles frozen.
  - While frozen = 1, digits holds the snapshot captured on the lap edge; internal counting and rollover continue unaffected.
  - A second lap in RUN releases the freeze; digits shows live time on the next cycle.
  - lap is ignored in IDLE and PAUSE.
  - clear, honoured in PAUSE, also releases the freeze. Reset releases it too.
- Undefined:
  - lap is ignored, frozen is constant 0, and digits always shows live time.
  - The snapshot register is not synthesized.

Test Plan (TICK_DIV=4):
- Reset: hold reset 2 cycles with start_stop=1 -> digits=16'h0000, running=0, rollover=0, state IDLE.
- Run: start_stop pulse, then 40 cycles -> running=1, digits=16'h0010. The 10th tick lands exactly at cycle 40 after RUN entry.
- Pause and resume:
  - Pause 2 cycles after the 2nd tick (digits=16'h0002), then wait 20 cycles -> digits stays 16'h0002.
  - Resume -> 16'h0003 appears after exactly 2 more cycles, since the prescaler was preserved.
- Wrap: run 5999 ticks -> digits=16'h9599. The next tick -> digits=16'h0000 with rollover=1 for exactly one cycle; the following tick -> 16'h0001.
- Clear rules:
  - clear in RUN -> ignored, counting continues.
  - In PAUSE at 16'h0123, clear+start_stop in the same cycle -> IDLE, digits=16'h0000, running=0.
- Lap (STOPWATCH_LAP_EN defined):
  - lap at 16'h0012, then 20 more ticks -> digits=16'h0012 and frozen=1.
  - Second lap -> digits=16'h0032 on the next cycle and frozen=0.
  - With the macro undefined, the same stimulus -> digits=16'h0032 live and frozen=0 throughout.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timekeeping core: prescaled tenth-second tick driving an M:SS.t BCD chain.
// Optional lap freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        rollover,
    output logic        frozen
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    localparam logic [CNT_W-1:0] PrescLast = CNT_W'(TICK_DIV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] presc_q;
    logic [3:0]       tenths_q, sec_units_q, sec_tens_q, min_q;
    logic             running_q, rollover_q;

    logic             tick;
    logic [4:0]       tenths_n, sec_units_n, sec_tens_n, min_n;
    logic [15:0]      live;

    // One BCD digit: wrap is detected before the add so the digit never leaves 0..max.
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic cin,
                                            input logic [3:0] max);
        logic wrap;
        wrap = cin && (d == max);
        return {wrap, wrap ? 4'd0 : d + {3'b000, cin}};
    endfunction

    // Tick detection and the ripple-carry increment chain.
    always_comb begin
        tick        = (state_q == StRun) && (presc_q == PrescLast);
        tenths_n    = bcd_step(tenths_q, tick, 4'd9);
        sec_units_n = bcd_step(sec_units_q, tenths_n[4], 4'd9);
        sec_tens_n  = bcd_step(sec_tens_q, sec_units_n[4], 4'd5);
        min_n       = bcd_step(min_q, sec_tens_n[4], 4'd9);
    end

    assign live = {min_q, sec_tens_q, sec_units_q, tenths_q};

    // Run/pause FSM, prescaler, digit registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            tenths_q    <= 4'd0;
            sec_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_q       <= 4'd0;
            running_q   <= 1'b0;
            rollover_q  <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            unique case (state_q)
                StIdle, StPause: begin
                    // clear takes priority over start_stop outside RUN
                    if (clear) begin
                        state_q     <= StIdle;
                        running_q   <= 1'b0;
                        presc_q     <= '0;
                        tenths_q    <= 4'd0;
                        sec_units_q <= 4'd0;
                        sec_tens_q  <= 4'd0;
                        min_q       <= 4'd0;
                    end else if (start_stop) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        tenths_q    <= tenths_n[3:0];
                        sec_units_q <= sec_units_n[3:0];
                        sec_tens_q  <= sec_tens_n[3:0];
                        min_q       <= min_n[3:0];
                        rollover_q  <= min_n[4];
                    end
                    if (start_stop) begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running  = running_q;
    assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic        frozen_q;
    logic [15:0] snap_q;

    // Lap freeze: snapshot the live time on the freezing edge, release on second lap or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            frozen_q <= 1'b0;
            snap_q   <= 16'h0000;
        end else if (state_q == StRun) begin
            if (lap) begin
                frozen_q <= !frozen_q;
                if (!frozen_q) begin
                    snap_q <= live;
                end
            end
        end else if (clear) begin
            frozen_q <= 1'b0;
        end
    end

    assign digits = frozen_q ? snap_q : live;
    assign frozen = frozen_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign digits     = live;
    assign frozen     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter with TICK_DIV=4.
module tb_stopwatch_bcd_counter;

    localparam int TickDiv = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LapEn = 1'b1;
`else
    localparam bit LapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start_stop, clear, lap;
    logic [15:0] digits;
    logic        running, rollover, frozen;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    stopwatch_bcd_counter #(
        .TICK_DIV(TickDiv),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .digits    (digits),
        .running   (running),
        .rollover  (rollover),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    // Model: elapsed time as a plain count of tenths, 0..5999, plus mode and phase.
    int m_mode;   // 0 idle, 1 run, 2 pause
    int m_phase, m_el, m_snap;
    bit m_roll, m_frozen;

    function automatic logic [15:0] to_bcd(input int e);
        logic [15:0] r;
        r[15:12] = 4'(e / 600);
        r[11:8]  = 4'((e / 100) % 6);
        r[7:4]   = 4'((e / 10) % 10);
        r[3:0]   = 4'(e % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_phase = 0; m_el = 0; m_roll = 0; m_frozen = 0; m_snap = 0;
        end else begin
            m_roll = 0;
            if (m_mode == 1) begin
                if (LapEn && lap) begin
                    if (!m_frozen) m_snap = m_el;
                    m_frozen = !m_frozen;
                end
                if (m_phase == TickDiv - 1) begin
                    m_phase = 0;
                    if (m_el == 5999) begin
                        m_el   = 0;
                        m_roll = 1;
                    end else begin
                        m_el = m_el + 1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
                if (start_stop) m_mode = 2;
            end else if (clear) begin
                m_mode = 0; m_phase = 0; m_el = 0; m_frozen = 0;
            end else if (start_stop) begin
                m_mode = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] exp_d;
            exp_d  = m_frozen ? to_bcd(m_snap) : to_bcd(m_el);
            checks = checks + 1;
            if (digits !== exp_d || running !== (m_mode == 1) || rollover !== m_roll
                || frozen !== m_frozen) begin
                failures = failures + 1;
                $display("FAIL model t=%0t digits=%h/%h running=%b/%b rollover=%b/%b frozen=%b/%b",
                         $time, digits, exp_d, running, (m_mode == 1), rollover, m_roll,
                         frozen, m_frozen);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cycles(2); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_stop = 1'b1; clear = 1'b0; lap = 1'b0;
        // Reset held two cycles with start_stop high.
        cycles(2);
        chk_en = 1'b1;
        check("reset_digits", digits, 16'h0000);
        check("reset_running", {15'd0, running}, 16'd0);
        check("reset_rollover", {15'd0, rollover}, 16'd0);
        start_stop = 1'b0; reset = 1'b0;

        // Run: tenth tick lands exactly 40 cycles after RUN entry.
        pulse_ss();
        cycles(39);
        check("run_39", digits, 16'h0009);
        cycles(1);
        check("run_40", digits, 16'h0010);
        check("run_running", {15'd0, running}, 16'd1);

        // Pause two cycles after the 2nd tick, then resume with preserved prescaler.
        do_reset();
        pulse_ss();
        cycles(8);
        check("tick2", digits, 16'h0002);
        cycles(1);
        pulse_ss();
        cycles(20);
        check("paused_hold", digits, 16'h0002);
        check("paused_running", {15'd0, running}, 16'd0);
        pulse_ss();
        cycles(1);
        check("resume_1", digits, 16'h0002);
        cycles(1);
        check("resume_2", digits, 16'h0003);

        // clear in RUN is ignored; clear+start_stop in RUN pauses without clearing.
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("clear_in_run", {15'd0, running}, 16'd1);
        cycles(8);
        check("clear_ignored", digits, 16'h0005);
        clear = 1'b1; start_stop = 1'b1; @(negedge clk); clear = 1'b0; start_stop = 1'b0;
        check("ss_wins_run", digits, 16'h0005);
        check("ss_wins_running", {15'd0, running}, 16'd0);

        // Wrap 9:59.9 -> 0:00.0 with a one-cycle rollover, counting continues.
        do_reset();
        pulse_ss();
        cycles(5999 * TickDiv);
        check("wrap_9599", digits, 16'h9599);
        cycles(TickDiv);
        check("wrap_0000", digits, 16'h0000);
        check("wrap_roll", {15'd0, rollover}, 16'd1);
        cycles(1);
        check("wrap_roll_off", {15'd0, rollover}, 16'd0);
        cycles(TickDiv - 1);
        check("wrap_0001", digits, 16'h0001);

        // PAUSE at 0:12.3, clear+start_stop together -> IDLE, cleared.
        do_reset();
        pulse_ss();
        cycles(123 * TickDiv);
        pulse_ss();
        check("pause_0123", digits, 16'h0123);
        clear = 1'b1; start_stop = 1'b1; @(negedge clk); clear = 1'b0; start_stop = 1'b0;
        check("clear_wins", digits, 16'h0000);
        check("clear_running", {15'd0, running}, 16'd0);

        // Lap freeze at 0:01.2, released 20 ticks later.
        do_reset();
        pulse_ss();
        cycles(12 * TickDiv);
        check("lap_at", digits, 16'h0012);
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        cycles(20 * TickDiv);
        check("lap_frozen_digits", digits, LapEn ? 16'h0012 : 16'h0032);
        check("lap_frozen_flag", {15'd0, frozen}, {15'd0, LapEn});
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        check("lap_release_digits", digits, 16'h0032);
        check("lap_release_flag", {15'd0, frozen}, 16'd0);
        cycles(4);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
